// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - shared-bus fetch/load/store access stage with stall and timeout
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_write,
  output logic              need_wait,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] load_data,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Abort fires on the BUSY cycle that would make the no-ack count reach TIMEOUT.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  wait_cnt;
  logic        is_fetch;
  logic        start, ack_hit, time_out;

  always_comb begin
    start    = 1'b0;
    ack_hit  = 1'b0;
    time_out = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        start = fetch_en | mem_en;
        if (start) state_nx = BUSY;
      end
      BUSY: begin
        ack_hit  = bus_ack;
        time_out = !bus_ack && (wait_cnt == LAST_WAIT);
        if (ack_hit || time_out) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign need_wait = (fetch_en | mem_en) & (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      is_fetch  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      instr     <= '0;
      load_data <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (start) begin
        // fetch_en wins when both enables are raised together
        bus_req   <= 1'b1;
        is_fetch  <= fetch_en;
        bus_addr  <= fetch_en ? pc : mem_addr;
        bus_we    <= fetch_en ? 1'b0 : mem_write;
        bus_wdata <= mem_wdata;
        wait_cnt  <= '0;
      end
      if (ack_hit) begin
        bus_req <= 1'b0;
        if (is_fetch)     instr     <= bus_rdata;
        else if (!bus_we) load_data <= bus_rdata;
      end else if (time_out) begin
        bus_req <= 1'b0;
        bus_err <= 1'b1;
        if (is_fetch)     instr     <= '1;
        else if (!bus_we) load_data <= '1;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0, mem_en = 1'b0, mem_write = 1'b0;
  logic [15:0] pc = '0, mem_addr = '0, mem_wdata = '0;
  logic        need_wait, bus_err, bus_req, bus_we;
  logic [15:0] instr, load_data, bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] m_instr = '0, m_load = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .mem_en(mem_en),
    .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .need_wait(need_wait), .instr(instr), .load_data(load_data), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_instr"}, instr, m_instr);
    check({tag, "_load"}, load_data, m_load);
    check({tag, "_err"}, 16'(bus_err), 16'(m_err));
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 both enables (fetch expected)
  task automatic run_access(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                            input int n, input bit no_ack, input logic [15:0] rdata);
    int  cycles, busy;
    bit  is_f;
    logic        exp_we;
    is_f   = (kind == 0 || kind == 3);
    exp_we = (kind == 2);
    fetch_en  = is_f;
    mem_en    = (kind != 0);
    pc        = is_f ? addr : 16'($urandom);
    mem_addr  = is_f ? 16'($urandom) : addr;
    mem_write = (kind == 2) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom);
    mem_wdata = wdata;
    cycles = 0;
    busy   = 0;
    while (cycles < 400) begin
      @(negedge clk);
      if (!need_wait) break;
      cycles++;
      if (bus_req) begin
        if (busy == 0 || busy == n) begin
          check("bus_addr", bus_addr, addr);
          check("bus_we", 16'(bus_we), 16'(exp_we));
          check("bus_wdata", bus_wdata, wdata);
        end
        bus_ack   = !no_ack && (busy == n);
        bus_rdata = bus_ack ? rdata : 16'($urandom);
        busy++;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    check("stall", 16'(cycles), no_ack ? 16'd256 : 16'(n + 2));
    check("req_done", 16'(bus_req), 16'd0);
    if (no_ack) begin
      m_err = 1'b1;
      if (is_f) m_instr = 16'hFFFF;
      else if (kind == 1) m_load = 16'hFFFF;
    end else begin
      if (is_f) m_instr = rdata;
      else if (kind == 1) m_load = rdata;
    end
    fetch_en = 1'b0;
    mem_en   = 1'b0;
    @(posedge clk); #1;
    check_regs("post");
  endtask

  initial begin
    #12;
    check("rst_req", 16'(bus_req), 16'd0);
    check("rst_we", 16'(bus_we), 16'd0);
    check("rst_addr", bus_addr, 16'd0);
    check("rst_wdata", bus_wdata, 16'd0);
    check("rst_wait", 16'(need_wait), 16'd0);
    check_regs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    run_access(0, 16'h0010, 16'h0000, 0, 1'b0, 16'h1234);
    run_access(1, 16'h0200, 16'h0000, 5, 1'b0, 16'hBEEF);
    run_access(2, 16'h0300, 16'h55AA, 3, 1'b0, 16'h0BAD);

    // spurious ack while idle
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 16'hDEAD;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    check_regs("spur");

    for (int i = 0; i < 40; i++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      run_access(k, 16'($urandom), 16'($urandom), int'($urandom_range(0, 8)), 1'b0,
                 16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end

    run_access(0, 16'h0040, 16'h1111, 0, 1'b1, 16'h0000);
    run_access(1, 16'h0041, 16'h2222, 0, 1'b1, 16'h0000);
    run_access(1, 16'h0042, 16'h3333, 2, 1'b0, 16'hCAFE);

    // reset in the middle of a fetch
    fetch_en = 1'b1; pc = 16'h0777;
    @(posedge clk); #1;
    check("mid_req", 16'(bus_req), 16'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_req", 16'(bus_req), 16'd0);
    check("arst_wait", 16'(need_wait), 16'd1);
    m_instr = '0; m_load = '0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    fetch_en = 1'b0;
    @(posedge clk); #1;
    check_regs("arst");
    run_access(0, 16'h0100, 16'h0000, 1, 1'b0, 16'h4321);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
